ram_access_master: RTL and testbench



---
 rtl/ram_access_pkg.sv | 14 +
 rtl/ram_rsp_fifo.sv | 51 +++++
 rtl/ram_access_master.sv | 173 +++++++++++++++++
 tb/tb_ram_access_master.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/ram_access_pkg.sv
// Shared types and constants for the RAM access master and its response buffer.
package ram_access_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        DRAIN = 2'd3
    } state_e;

    localparam int RSP_DEPTH = 2;
    localparam int PERF_W    = 16;

endpackage

// File: rtl/ram_rsp_fifo.sv
// Two-entry synchronous FIFO holding {last, data} read beats for the response stream.
module ram_rsp_fifo
    import ram_access_pkg::*;
#(
    parameter int WIDTH = 9
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    logic [WIDTH-1:0] mem_q [RSP_DEPTH];
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    logic [1:0]       count_q;
    logic             push_ok;
    logic             pop_ok;

    assign o_empty = (count_q == 2'd0);
    assign o_full  = (count_q == 2'd2);
    assign pop_ok  = i_pop && !o_empty;
    // A push into a full buffer is only legal when the head leaves in the same cycle.
    assign push_ok = i_push && (!o_full || pop_ok);
    assign o_data  = mem_q[rd_ptr_q];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < RSP_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= i_data;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop_ok) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + {1'b0, push_ok} - {1'b0, pop_ok};
        end
    end

endmodule

// File: rtl/ram_access_master.sv
// Burst read/write initiator for the single-port RAM with a buffered read response stream.
// Optional beat counters (o_wr_beats/o_rd_beats) are built when RAM_ACCESS_PERF_EN is defined.
module ram_access_master
    import ram_access_pkg::*;
#(
    parameter int SIZE_ADDR = 8,
    parameter int SIZE_DATA = 8,
    parameter int SIZE_LEN  = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_req_valid,
    output logic                 o_req_ready,
    input  logic                 i_req_write,
    input  logic [SIZE_ADDR-1:0] i_req_addr,
    input  logic [SIZE_LEN-1:0]  i_req_len,
    input  logic                 i_wdata_valid,
    output logic                 o_wdata_ready,
    input  logic [SIZE_DATA-1:0] i_wdata,
    output logic                 o_rdata_valid,
    input  logic                 i_rdata_ready,
    output logic [SIZE_DATA-1:0] o_rdata,
    output logic                 o_rdata_last,
    output logic                 o_ram_rd_en,
    output logic                 o_ram_wr_en,
    output logic [SIZE_ADDR-1:0] o_ram_addr,
    output logic [SIZE_DATA-1:0] o_ram_data,
    input  logic [SIZE_DATA-1:0] i_ram_data,
`ifdef RAM_ACCESS_PERF_EN
    output logic [PERF_W-1:0]    o_wr_beats,
    output logic [PERF_W-1:0]    o_rd_beats,
`endif
    output logic                 o_busy,
    output logic                 o_done
);

    state_e               state_q, state_d;
    logic [SIZE_ADDR-1:0] cur_addr_q, cur_addr_d;
    logic [SIZE_LEN-1:0]  remain_q, remain_d;
    logic                 inflight_q, inflight_d;
    logic                 inflight_last_q, inflight_last_d;
    logic                 done_q, done_d;

    logic                 fifo_full;
    logic                 fifo_empty;
    logic [SIZE_DATA:0]   fifo_head;
    logic [1:0]           fifo_count;
    logic [1:0]           occ_after;
    logic                 pop;

    assign pop        = !fifo_empty && i_rdata_ready;
    assign fifo_count = {fifo_full, !fifo_empty && !fifo_full};
    // Occupancy once this cycle's pop leaves; counting the in-flight beat keeps the buffer from overflowing.
    assign occ_after  = fifo_count + {1'b0, inflight_q} - {1'b0, pop};

    always_comb begin
        state_d         = state_q;
        cur_addr_d      = cur_addr_q;
        remain_d        = remain_q;
        inflight_d      = 1'b0;
        inflight_last_d = 1'b0;
        done_d          = 1'b0;
        o_req_ready     = 1'b0;
        o_wdata_ready   = 1'b0;
        o_ram_wr_en     = 1'b0;
        o_ram_rd_en     = 1'b0;
        o_ram_data      = '0;
        case (state_q)
            IDLE: begin
                o_req_ready = 1'b1;
                if (i_req_valid) begin
                    cur_addr_d = i_req_addr;
                    remain_d   = i_req_len;
                    state_d    = i_req_write ? WRITE : READ;
                end
            end
            WRITE: begin
                o_wdata_ready = 1'b1;
                o_ram_data    = i_wdata;
                o_ram_wr_en   = i_wdata_valid;
                if (i_wdata_valid) begin
                    cur_addr_d = cur_addr_q + SIZE_ADDR'(1);
                    remain_d   = remain_q - SIZE_LEN'(1);
                    if (remain_q == '0) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            READ: begin
                if (occ_after < 2'd2) begin
                    o_ram_rd_en     = 1'b1;
                    inflight_d      = 1'b1;
                    inflight_last_d = (remain_q == '0);
                    cur_addr_d      = cur_addr_q + SIZE_ADDR'(1);
                    remain_d        = remain_q - SIZE_LEN'(1);
                    if (remain_q == '0) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (fifo_empty && !inflight_q) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q         <= IDLE;
            cur_addr_q      <= '0;
            remain_q        <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            done_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            cur_addr_q      <= cur_addr_d;
            remain_q        <= remain_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
            done_q          <= done_d;
        end
    end

    // RAM output is only valid the cycle after an issue, so capture is tied to the in-flight flag.
    ram_rsp_fifo #(
        .WIDTH(SIZE_DATA + 1)
    ) u_rsp_fifo (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .i_push (inflight_q),
        .i_pop  (pop),
        .i_data ({inflight_last_q, i_ram_data}),
        .o_data (fifo_head),
        .o_full (fifo_full),
        .o_empty(fifo_empty)
    );

    assign o_rdata_valid = !fifo_empty;
    assign o_rdata       = fifo_head[SIZE_DATA-1:0];
    assign o_rdata_last  = fifo_head[SIZE_DATA];
    assign o_ram_addr    = cur_addr_q;
    assign o_busy        = (state_q != IDLE);
    assign o_done        = done_q;

`ifdef RAM_ACCESS_PERF_EN
    logic [PERF_W-1:0] wr_beats_q;
    logic [PERF_W-1:0] rd_beats_q;

    function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
        return (v == '1) ? v : v + PERF_W'(1);
    endfunction

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_beats_q <= '0;
            rd_beats_q <= '0;
        end else begin
            if (o_ram_wr_en) wr_beats_q <= sat_inc(wr_beats_q);
            if (pop)         rd_beats_q <= sat_inc(rd_beats_q);
        end
    end

    assign o_wr_beats = wr_beats_q;
    assign o_rd_beats = rd_beats_q;
`endif

endmodule

// File: tb/tb_ram_access_master.sv
// Directed bench for ram_access_master with a behavioural single-port RAM behind it.
module tb_ram_access_master;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid, req_write;
    logic [7:0] req_addr;
    logic [3:0] req_len;
    logic       wdata_valid;
    logic [7:0] wdata;
    logic       rdata_ready;
    logic       o_req_ready, o_wdata_ready, o_rdata_valid, o_rdata_last;
    logic [7:0] o_rdata;
    logic       o_ram_rd_en, o_ram_wr_en;
    logic [7:0] o_ram_addr, o_ram_data;
    logic [7:0] ram_q;
    logic       o_busy, o_done;
`ifdef RAM_ACCESS_PERF_EN
    logic [15:0] o_wr_beats, o_rd_beats;
`endif

    logic [7:0] ram_mem [256];

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    // Registered-read RAM: output holds when rd_en is low.
    always @(posedge clk) begin
        if (o_ram_wr_en) ram_mem[o_ram_addr] <= o_ram_data;
        if (o_ram_rd_en) ram_q <= ram_mem[o_ram_addr];
    end

    ram_access_master #(
        .SIZE_ADDR(8),
        .SIZE_DATA(8),
        .SIZE_LEN (4)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_req_valid  (req_valid),
        .o_req_ready  (o_req_ready),
        .i_req_write  (req_write),
        .i_req_addr   (req_addr),
        .i_req_len    (req_len),
        .i_wdata_valid(wdata_valid),
        .o_wdata_ready(o_wdata_ready),
        .i_wdata      (wdata),
        .o_rdata_valid(o_rdata_valid),
        .i_rdata_ready(rdata_ready),
        .o_rdata      (o_rdata),
        .o_rdata_last (o_rdata_last),
        .o_ram_rd_en  (o_ram_rd_en),
        .o_ram_wr_en  (o_ram_wr_en),
        .o_ram_addr   (o_ram_addr),
        .o_ram_data   (o_ram_data),
        .i_ram_data   (ram_q),
`ifdef RAM_ACCESS_PERF_EN
        .o_wr_beats   (o_wr_beats),
        .o_rd_beats   (o_rd_beats),
`endif
        .o_busy       (o_busy),
        .o_done       (o_done)
    );

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_vec({tag, "_req_ready"},   o_req_ready,   1);
        check_vec({tag, "_busy"},        o_busy,        0);
        check_vec({tag, "_done"},        o_done,        0);
        check_vec({tag, "_rdata_valid"}, o_rdata_valid, 0);
        check_vec({tag, "_rd_en"},       o_ram_rd_en,   0);
        check_vec({tag, "_wr_en"},       o_ram_wr_en,   0);
        check_vec({tag, "_ram_addr"},    o_ram_addr,    0);
        check_vec({tag, "_wdata_ready"}, o_wdata_ready, 0);
        check_vec({tag, "_rdata"},       o_rdata,       0);
    endtask

    task automatic do_write(input logic [7:0] addr, input logic [3:0] len,
                            input logic [7:0] d0, input logic [7:0] ds);
        logic [7:0] ea, ed;
        @(negedge clk);
        check_vec("wr_req_ready", o_req_ready, 1);
        req_valid = 1'b1; req_write = 1'b1; req_addr = addr; req_len = len;
        @(negedge clk);
        req_valid = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            ea = addr + 8'(i);
            ed = d0 + 8'(i) * ds;
            wdata_valid = 1'b1;
            wdata       = ed;
            #1;
            check_vec("wr_wdata_ready", o_wdata_ready, 1);
            check_vec("wr_en",   o_ram_wr_en, 1);
            check_vec("wr_addr", o_ram_addr,  ea);
            check_vec("wr_data", o_ram_data,  ed);
            @(negedge clk);
        end
        wdata_valid = 1'b0;
        #1;
        check_vec("wr_done",      o_done,      1);
        check_vec("wr_busy",      o_busy,      0);
        check_vec("wr_idle_wren", o_ram_wr_en, 0);
    endtask

    // stall_at < 0 disables back-pressure; otherwise ready drops for stall_n cycles after stall_at beats.
    task automatic do_read(input logic [7:0] addr, input logic [3:0] len,
                           input logic [7:0] d0, input logic [7:0] ds,
                           input int stall_at, input int stall_n, input bit chk_lat);
        int k, got_n, issued, max_out, stall_left;
        bit done_seen;
        logic [7:0] ed;
        @(negedge clk);
        check_vec("rd_req_ready", o_req_ready, 1);
        req_valid = 1'b1; req_write = 1'b0; req_addr = addr; req_len = len;
        rdata_ready = 1'b1;
        @(negedge clk);
        req_valid  = 1'b0;
        k          = 1;
        got_n      = 0;
        issued     = 0;
        max_out    = 0;
        stall_left = -1;
        done_seen  = 1'b0;
        while (!done_seen && k < 80) begin
            if (got_n == stall_at && stall_left < 0) stall_left = stall_n;
            rdata_ready = (stall_left <= 0);
            #1;
            if (chk_lat && k == 2) check_vec("rd_lat_early", o_rdata_valid, 0);
            if (chk_lat && k == 3) check_vec("rd_lat_first", o_rdata_valid, 1);
            if (o_done) done_seen = 1'b1;
            if (o_ram_rd_en) issued++;
            if (o_rdata_valid && rdata_ready) begin
                ed = d0 + 8'(got_n) * ds;
                check_vec("rd_data", o_rdata, ed);
                check_vec("rd_last", o_rdata_last, (got_n == int'(len)) ? 1 : 0);
                if (chk_lat) check_vec("rd_b2b_cycle", k, 3 + got_n);
                got_n++;
            end
            if (issued - got_n > max_out) max_out = issued - got_n;
            if (stall_left > 0) stall_left--;
            @(negedge clk);
            k++;
        end
        check_vec("rd_done_seen",   done_seen, 1);
        check_vec("rd_beats",       got_n,     int'(len) + 1);
        check_vec("rd_issues",      issued,    int'(len) + 1);
        check_vec("rd_outstanding", (max_out <= 2) ? 1 : 0, 1);
        if (stall_at >= 0) check_vec("rd_stall_filled", max_out, 2);
        #1;
        check_vec("rd_no_extra", o_rdata_valid, 0);
        check_vec("rd_busy_end", o_busy,        0);
    endtask

    initial begin
        int issued;
        rst_n       = 1'b0;
        req_valid   = 1'b0;
        req_write   = 1'b0;
        req_addr    = '0;
        req_len     = '0;
        wdata_valid = 1'b0;
        wdata       = '0;
        rdata_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_reset_outputs("rst0");
        rst_n = 1'b1;

        do_write(8'h10, 4'd3, 8'hA1, 8'h01);
        do_read (8'h10, 4'd3, 8'hA1, 8'h01, -1, 0, 1'b1);

        do_write(8'hFE, 4'd2, 8'h11, 8'h11);
        do_read (8'hFE, 4'd2, 8'h11, 8'h11, -1, 0, 1'b0);

        do_write(8'h20, 4'd7, 8'h50, 8'h01);
        do_read (8'h20, 4'd7, 8'h50, 8'h01, 2, 5, 1'b0);

        // Abort a read on its third issue with reset, then confirm recovery.
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 8'h20; req_len = 4'd7;
        rdata_ready = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        issued = 0;
        for (int c = 0; c < 20 && issued < 3; c++) begin
            #1;
            if (o_ram_rd_en) issued++;
            if (issued < 3) @(negedge clk);
        end
        check_vec("rst_mid_issues", issued, 3);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rst_mid");
        @(negedge clk);
        @(negedge clk);
        check_reset_outputs("rst_hold");
        rst_n = 1'b1;
        do_read(8'h20, 4'd3, 8'h50, 8'h01, -1, 0, 1'b1);

        do_write(8'h30, 4'd3, 8'hC0, 8'h01);
`ifdef RAM_ACCESS_PERF_EN
        check_vec("perf_wr_beats", o_wr_beats, 4);
        check_vec("perf_rd_beats", o_rd_beats, 4);
`endif
        do_read(8'h30, 4'd3, 8'hC0, 8'h01, -1, 0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
